param_hasher: RTL and testbench
===============================

// Module: param_hasher
// PURPOSE
//  Parametrised iterative rolling hasher for the key-fob OTP path. On each start
//  strobe, folds (cur_time ^ student_id) into the running hash over ROUNDS
//  square-and-shift rounds, one round per clock. Publishes the new hash with a
//  one-cycle done pulse. Sits between the time counter and the display/compare logic.
//  Adds async reset, a seed load, and a start/busy/done handshake.
// PARAMETERS
//  W      16   hash, time and id width in bits (W >= 4)
//  ROUNDS 1    square-and-shift rounds per hash update (ROUNDS >= 1)
//  SHIFT  8    right shift applied to the 2W-bit square (0 <= SHIFT < 2W)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   reset: asynchronous, active-high
//  start       in   1   request one hash update; sampled only in IDLE
//  seed_load   in   1   load seed into cur_hash; sampled only in IDLE
//  seed        in   W   value loaded by seed_load
//  cur_time    in   W   current time step; captured on the accepted start
//  student_id  in   W   device/user id; captured on the accepted start
//  busy        out  1   high when state != IDLE
//  done        out  1   one-cycle pulse: cur_hash has just been updated
//  cur_hash    out  W   registered hash value
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cur_hash=0, done=0, busy=0,
//   internal x/acc/round counter=0. Reset mid-RUN aborts; no done pulse.
//  Round function f(acc), all in 2W bits, modulo 2^(2W):
//   d = {W'b0,x} - {W'b0,acc}  (wraps when acc > x)
//   p = d*d mod 2^(2W);  f = (p >> SHIFT)[W-1:0]
//   W=16, SHIFT=8 gives the existing single-step hash exactly.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: seed_load=1 -> cur_hash<=seed, stay IDLE. seed_load wins if both
//    seed_load and start are high; that start is dropped.
//    start=1 (seed_load=0) -> x<=cur_time^student_id, acc<=cur_hash, cnt<=0, go RUN.
//   RUN: each edge acc<=f(acc), cnt<=cnt+1. On the edge where cnt==ROUNDS-1:
//    cur_hash<=f(acc), go DONE.
//   DONE: done=1 for this cycle only, go IDLE on next edge.
//  Latency: start accepted at edge k. cur_hash changes at edge k+ROUNDS.
//   done is high between edges k+ROUNDS and k+ROUNDS+1. The next start is
//   accepted at edge k+ROUNDS+2 at the earliest.
//  start and seed_load are ignored in RUN and DONE; they are not queued.
//  cur_time and student_id may change freely after capture.
//  cur_hash holds its value in all states except the update edges above.
//  done is registered; cur_hash is never X after reset.
//  Round counter width is clog2(ROUNDS)+1. ROUNDS=1 takes one RUN cycle.
// TESTING  (W=16, SHIFT=8 unless noted)
//  1 Reset: assert rst mid-RUN -> immediately cur_hash=0, busy=0, done=0;
//    no done after release.
//  2 ROUNDS=1, cur_hash=0, time=0x0100, id=0x0000, start -> cur_hash=0x0100,
//    done at k+1. Repeat start -> 0x0000.
//  3 Wrap: seed_load seed=0x0010, then start with time=0x0000, id=0x0000
//    -> d=0xFFFFFFF0, cur_hash=0x0001.
//  4 ROUNDS=2, cur_hash=0, time^id=0x0100 -> rounds give 0x0100 then 0x0000.
//    cur_hash=0x0000 at edge k+2, done in cycle k+2..k+3.
//  5 Handshake: start held high continuously -> one update per ROUNDS+2 cycles.
//    seed_load during RUN is ignored. seed_load and start together in IDLE
//    -> seed loaded, no hash update.
//  6 Random: 1000 starts with random time, id and seeds -> cur_hash matches
//    the f() reference model; done count equals accepted starts.

Source files
------------

// File: rtl/param_hasher.sv
// Iterative rolling hasher: folds (cur_time ^ student_id) into the running hash
// over ROUNDS square-and-shift rounds, one per clock, with a start/busy/done handshake.
module param_hasher #(
  parameter int unsigned W      = 16,
  parameter int unsigned ROUNDS = 1,
  parameter int unsigned SHIFT  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] cur_time,
  input  logic [W-1:0] student_id,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] cur_hash
);

  localparam int unsigned CW = $clog2(ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     hash_q, hash_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [2*W-1:0]   diff;
  logic [2*W-1:0]   sq;
  logic [W-1:0]     f_acc;
  logic             last_round;

  // Round function evaluated in 2W bits; the subtraction wraps when acc > x.
  always_comb begin
    diff       = {{W{1'b0}}, x_q} - {{W{1'b0}}, acc_q};
    sq         = diff * diff;
    f_acc      = W'(sq >> SHIFT);
    last_round = (cnt_q == CW'(ROUNDS - 1));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    hash_d  = hash_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          hash_d = seed;
        end else if (start) begin
          x_d     = cur_time ^ student_id;
          acc_d   = hash_q;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = f_acc;
        cnt_d = cnt_q + CW'(1);
        if (last_round) begin
          hash_d  = f_acc;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      hash_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cur_hash = hash_q;

endmodule

// File: tb/tb_param_hasher.sv
// Randomised self-checking bench: two hashers (ROUNDS=1 and ROUNDS=2) compared
// against an arithmetic reference of the hash rule and the handshake timing.
module tb_param_hasher;

  localparam int unsigned RA = 1;
  localparam int unsigned RB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start;
  logic [1:0]  seed_load;
  logic [15:0] seed [2];
  logic [15:0] tim  [2];
  logic [15:0] sid  [2];
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [15:0] hash [2];

  int checks = 0;
  int errors = 0;
  logic [15:0] mh [2];
  int accepted [2];
  int dcnt [2];

  always #5 clk = ~clk;

  param_hasher #(.W(16), .ROUNDS(RA), .SHIFT(8)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .seed_load(seed_load[0]),
    .seed(seed[0]), .cur_time(tim[0]), .student_id(sid[0]),
    .busy(busy[0]), .done(done[0]), .cur_hash(hash[0])
  );

  param_hasher #(.W(16), .ROUNDS(RB), .SHIFT(8)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .seed_load(seed_load[1]),
    .seed(seed[1]), .cur_time(tim[1]), .student_id(sid[1]),
    .busy(busy[1]), .done(done[1]), .cur_hash(hash[1])
  );

  always @(negedge clk) begin
    if (done[0]) dcnt[0] = dcnt[0] + 1;
    if (done[1]) dcnt[1] = dcnt[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rnds(input int sel);
    return (sel == 0) ? RA : RB;
  endfunction

  // (x - acc) mod 2^32, squared mod 2^32, then bits [23:8] via division.
  function automatic logic [15:0] f_ref(input logic [15:0] acc, input logic [15:0] x);
    longint unsigned d, p;
    d = (longint'(x) + 64'h1_0000_0000 - longint'(acc)) % 64'h1_0000_0000;
    p = (d * d) % 64'h1_0000_0000;
    return 16'((p / 256) % 65536);
  endfunction

  function automatic logic [15:0] hash_ref(input logic [15:0] h, input logic [15:0] x,
                                           input int unsigned r);
    logic [15:0] a;
    a = h;
    for (int unsigned i = 0; i < r; i++) a = f_ref(a, x);
    return a;
  endfunction

  task automatic do_start(input int sel, input logic [15:0] t, input logic [15:0] id,
                          input bit poke);
    int n;
    logic [15:0] exp;
    @(negedge clk);
    start[sel] = 1'b1;
    tim[sel]   = t;
    sid[sel]   = id;
    exp = hash_ref(mh[sel], t ^ id, rnds(sel));
    @(posedge clk);
    accepted[sel]++;
    @(negedge clk);
    start[sel]     = poke;
    seed_load[sel] = poke;
    seed[sel]      = ~exp;
    tim[sel]       = 16'($urandom);
    sid[sel]       = 16'($urandom);
    check("busy_run", 32'(busy[sel]), 32'd1);
    n = 0;
    while (done[sel] !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      start[sel]     = 1'b0;
      seed_load[sel] = 1'b0;
    end
    check("latency", 32'(n), 32'(rnds(sel)));
    check("hash", 32'(hash[sel]), 32'(exp));
    @(posedge clk);
    #1;
    check("done_low", 32'(done[sel]), 32'd0);
    check("busy_idle", 32'(busy[sel]), 32'd0);
    mh[sel] = exp;
  endtask

  task automatic load_seed(input int sel, input logic [15:0] s, input bit with_start);
    @(negedge clk);
    seed_load[sel] = 1'b1;
    start[sel]     = with_start;
    seed[sel]      = s;
    @(posedge clk);
    #1;
    check("seed_hash", 32'(hash[sel]), 32'(s));
    check("seed_busy", 32'(busy[sel]), 32'd0);
    @(negedge clk);
    seed_load[sel] = 1'b0;
    start[sel]     = 1'b0;
    mh[sel] = s;
  endtask

  task automatic hold_start(input int sel, input logic [15:0] t, input logic [15:0] id);
    int unsigned p;
    int d0;
    p = rnds(sel) + 2;
    @(negedge clk);
    start[sel] = 1'b1;
    tim[sel]   = t;
    sid[sel]   = id;
    d0 = dcnt[sel];
    repeat (4 * p) @(posedge clk);
    @(negedge clk);
    start[sel] = 1'b0;
    check("hold_dones", 32'(dcnt[sel] - d0), 32'd4);
    for (int i = 0; i < 4; i++) mh[sel] = hash_ref(mh[sel], t ^ id, rnds(sel));
    accepted[sel] += 4;
    check("hold_hash", 32'(hash[sel]), 32'(mh[sel]));
    check("hold_busy", 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int d_snap;
    rst = 1'b1;
    start = '0;
    seed_load = '0;
    for (int i = 0; i < 2; i++) begin
      seed[i] = '0; tim[i] = '0; sid[i] = '0;
      mh[i] = '0; accepted[i] = 0; dcnt[i] = 0;
    end
    #22;
    for (int i = 0; i < 2; i++) begin
      check("rst_hash", 32'(hash[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a RUN.
    load_seed(0, 16'h5555, 1'b0);
    load_seed(1, 16'hAAAA, 1'b0);
    @(negedge clk);
    start[1] = 1'b1;
    tim[1]   = 16'h1234;
    sid[1]   = 16'h00FF;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    check("pre_rst_busy", 32'(busy[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_hash", 32'(hash[i]), 32'd0);
      check("arst_busy", 32'(busy[i]), 32'd0);
      check("arst_done", 32'(done[i]), 32'd0);
    end
    d_snap = dcnt[1];
    @(negedge clk);
    rst = 1'b0;
    mh[0] = '0;
    mh[1] = '0;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(dcnt[1]), 32'(d_snap));

    // Directed single-round and wrap cases.
    do_start(0, 16'h0100, 16'h0000, 1'b0);
    check("t2_first", 32'(hash[0]), 32'h0100);
    do_start(0, 16'h0100, 16'h0000, 1'b0);
    check("t2_second", 32'(hash[0]), 32'h0000);
    load_seed(0, 16'h0010, 1'b0);
    do_start(0, 16'h0000, 16'h0000, 1'b0);
    check("t3_wrap", 32'(hash[0]), 32'h0001);

    // Two rounds: 0x0100 then 0x0000.
    do_start(1, 16'h0180, 16'h0080, 1'b0);
    check("t4_two_round", 32'(hash[1]), 32'h0000);

    // Handshake: held start, pokes during RUN, seed_load winning over start.
    hold_start(0, 16'h3C3C, 16'h0F0F);
    hold_start(1, 16'h9999, 16'h1111);
    do_start(0, 16'h4321, 16'h0101, 1'b1);
    do_start(1, 16'h7777, 16'h0606, 1'b1);
    d_snap = dcnt[0];
    load_seed(0, 16'h1234, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("seed_wins_no_done", 32'(dcnt[0]), 32'(d_snap));
    check("seed_wins_hash", 32'(hash[0]), 32'h1234);

    for (int i = 0; i < 1000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) load_seed(sel, 16'($urandom), 1'b0);
      do_start(sel, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("done_count_a", 32'(dcnt[0]), 32'(accepted[0]));
    check("done_count_b", 32'(dcnt[1]), 32'(accepted[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
